// File: rtl/sram_dp.sv
// sram_dp: single-clock memory with one byte-masked write port and NUM_READ
// registered read ports. After reset, an internal sweep writes RESET_VALUE to
// every word. Accesses are accepted only after that sweep completes (ready=1).
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   write_enable  write request for the current cycle
//   write_addr    write address (AW bits)
//   write_word    write data (WIDTH bits, signed)
//   write_mask    byte enables; bit i gates byte [8i+7:8i]
//   read_enable   per-port read request (NUM_READ bits)
//   read_addr     packed read addresses; port p at [p*AW +: AW]
//   word          packed registered read data; port p at [p*WIDTH +: WIDTH]
//   ready         high once initialisation is complete
module sram_dp #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 256,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      NUM_READ    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            write_enable,
    input  logic [$clog2(DEPTH)-1:0]        write_addr,
    input  logic signed [WIDTH-1:0]         write_word,
    input  logic [WIDTH/8-1:0]              write_mask,
    input  logic [NUM_READ-1:0]             read_enable,
    input  logic [NUM_READ*$clog2(DEPTH)-1:0] read_addr,
    output logic [NUM_READ*WIDTH-1:0]       word,
    output logic                            ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   init_cnt;
    logic [AW-1:0]   init_cnt_next;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_hit;
    logic [WIDTH-1:0] merged;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [NB-1:0]    mem_be;

    logic [AW-1:0]    rd_addr [NUM_READ];
    logic [WIDTH-1:0] rd_data [NUM_READ];

    // State register, init counter and ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            ready    <= (state_next == RUN);
        end
    end

    // Next state: sweep addresses 0..DEPTH-1, then run until reset
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            INIT: begin
                init_cnt_next = init_cnt + AW'(1);
                if (init_cnt == AW'(DEPTH - 1)) begin
                    state_next    = RUN;
                    init_cnt_next = '0;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Write port selection; merged is the post-write word used for forwarding
    always_comb begin
        wr_hit   = (state == RUN) && write_enable && (32'(write_addr) < DEPTH);
        merged   = mem[write_addr];
        mem_we   = 1'b0;
        mem_addr = write_addr;
        mem_data = write_word;
        mem_be   = write_mask;
        for (int b = 0; b < int'(NB); b++) begin
            if (write_mask[b]) begin
                merged[8*b +: 8] = write_word[8*b +: 8];
            end
        end
        if (state == INIT) begin
            mem_we   = 1'b1;
            mem_addr = init_cnt;
            mem_data = RESET_VALUE;
            mem_be   = '1;
        end else begin
            mem_we   = wr_hit;
        end
    end

    // Byte-enabled storage array
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
                end
            end
        end
    end

    // Read data per port: out-of-range reads give RESET_VALUE, same-address
    // write in this cycle is forwarded (write-first)
    always_comb begin
        for (int p = 0; p < int'(NUM_READ); p++) begin
            rd_addr[p] = read_addr[p*AW +: AW];
            if (32'(rd_addr[p]) >= DEPTH) begin
                rd_data[p] = RESET_VALUE;
            end else if (wr_hit && (rd_addr[p] == write_addr)) begin
                rd_data[p] = merged;
            end else begin
                rd_data[p] = mem[rd_addr[p]];
            end
        end
    end

    // Registered read outputs; hold when not enabled or not ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= {NUM_READ{RESET_VALUE}};
        end else if (state == RUN) begin
            for (int p = 0; p < int'(NUM_READ); p++) begin
                if (read_enable[p]) begin
                    word[p*WIDTH +: WIDTH] <= rd_data[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_dp.sv
// tb_sram_dp: randomized and directed stimulus for sram_dp (DEPTH=200, two
// read ports). Each stimulus cycle updates a behavioural model and queues the
// expected outputs; a separate monitor pops and compares after every edge,
// and checks the asynchronous reset effect right after reset rises.
module tb_sram_dp;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 200;
    localparam int unsigned NR = 2;
    localparam int unsigned AW = $clog2(D);
    localparam int unsigned NB = W / 8;
    localparam logic [W-1:0] RV = 32'h5A5A_C3C3;

    logic                 clk;
    logic                 reset;
    logic                 write_enable;
    logic [AW-1:0]        write_addr;
    logic signed [W-1:0]  write_word;
    logic [NB-1:0]        write_mask;
    logic [NR-1:0]        read_enable;
    logic [NR*AW-1:0]     read_addr;
    logic [NR*W-1:0]      word;
    logic                 ready;

    sram_dp #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV),
        .NUM_READ    (NR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_word   (write_word),
        .write_mask   (write_mask),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .word         (word),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR*W-1:0] w;
        logic            rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: memory contents, output words, ready flag
    logic [W-1:0] m_mem  [D];
    logic [W-1:0] m_word [NR];
    logic         m_ready = 1'b0;
    int           m_left  = 0;

    // Drive one cycle of inputs, predict the effect of the next edge, queue it
    task automatic tick(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [NB-1:0] wm,
                        input logic [NR-1:0] re, input logic [AW-1:0] ra0,
                        input logic [AW-1:0] ra1);
        exp_t          e;
        logic [AW-1:0] ra;
        reset        = rst;
        write_enable = we;
        write_addr   = wa;
        write_word   = wd;
        write_mask   = wm;
        read_enable  = re;
        read_addr    = {ra1, ra0};
        if (rst) begin
            m_ready = 1'b0;
            m_left  = int'(D);
            for (int p = 0; p < int'(NR); p++) m_word[p] = RV;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int a = 0; a < int'(D); a++) m_mem[a] = RV;
            end
        end else begin
            if (we && (32'(wa) < D)) begin
                for (int b = 0; b < int'(NB); b++)
                    if (wm[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
            end
            for (int p = 0; p < int'(NR); p++) begin
                ra = (p == 0) ? ra0 : ra1;
                if (re[p]) m_word[p] = (32'(ra) < D) ? m_mem[ra] : RV;
            end
        end
        e.w   = {m_word[1], m_word[0]};
        e.rdy = m_ready;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int s = int'($urandom_range(0, 9));
        if (s < 5)      return AW'($urandom_range(0, 15));
        else if (s < 7) return AW'($urandom_range(190, 255));
        else            return AW'($urandom_range(0, 255));
    endfunction

    task automatic rnd_tick(input logic rst);
        tick(rst, 1'($urandom_range(0, 1)), rnd_addr(), W'($urandom), NB'($urandom),
             NR'($urandom), rnd_addr(), rnd_addr());
    endtask

    // Run random-access cycles until the model reports ready (bounded)
    task automatic run_init();
        for (int i = 0; i < int'(D) + 4 && !m_ready; i++) rnd_tick(1'b0);
    endtask

    // Monitor: after each rising edge compare against the queue; right after
    // reset rises (clock low) check the asynchronous reset values
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (!clk) begin
                n_cmp++;
                if (word !== {NR{RV}} || ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL async_reset t=%0t: word=%h ready=%b, required word=%h ready=0",
                             $time, word, ready, {NR{RV}});
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (word !== e.w || ready !== e.rdy) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t: word=%h ready=%b, required word=%h ready=%b",
                             $time, word, ready, e.w, e.rdy);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset        = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        write_word   = '0;
        write_mask   = '0;
        read_enable  = '0;
        read_addr    = '0;
        @(negedge clk);

        // Power-up reset, then accesses during deassert cycle and INIT are ignored
        repeat (3) tick(1'b1, 1'b1, AW'(5), 32'hDEAD_BEEF, '1, '1, AW'(5), AW'(6));
        tick(1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, '1, '1, AW'(5), AW'(6));
        run_init();

        // Every address reads RESET_VALUE after init
        for (int a = 0; a < int'(D); a += 2) tick(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(a + 1));
        idle();

        // Basic write then reads
        tick(1'b0, 1'b1, AW'(5), 32'd42, 4'b1111, 2'b00, '0, '0);
        tick(1'b0, 1'b0, '0, '0, '0, 2'b01, AW'(5), '0);
        tick(1'b0, 1'b0, '0, '0, '0, 2'b01, AW'(0), '0);
        tick(1'b0, 1'b0, '0, '0, '0, 2'b01, AW'(5), '0);

        // Byte mask merge
        tick(1'b0, 1'b1, AW'(7), 32'h1122_3344, 4'b1111, 2'b00, '0, '0);
        tick(1'b0, 1'b1, AW'(7), 32'hAABB_CCDD, 4'b0101, 2'b00, '0, '0);
        tick(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(7), AW'(7));

        // Write-first forwarding with two ports, including masked forward
        tick(1'b0, 1'b1, AW'(3), 32'd99, 4'b1111, 2'b11, AW'(3), AW'(5));
        tick(1'b0, 1'b1, AW'(7), 32'h0102_0304, 4'b1010, 2'b11, AW'(7), AW'(3));

        // Zero mask changes nothing
        tick(1'b0, 1'b1, AW'(5), 32'hFFFF_FFFF, 4'b0000, 2'b11, AW'(5), AW'(5));
        tick(1'b0, 1'b0, '0, '0, '0, 2'b01, AW'(5), '0);

        // Boundaries: last address, out-of-range write and read, hold
        tick(1'b0, 1'b1, AW'(199), 32'd7, 4'b1111, 2'b00, '0, '0);
        tick(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(199), AW'(3));
        tick(1'b0, 1'b1, AW'(250), 32'h7777_7777, 4'b1111, 2'b10, '0, AW'(250));
        tick(1'b0, 1'b0, '0, '0, '0, 2'b01, AW'(250), '0);
        tick(1'b0, 1'b1, AW'(199), 32'h1234_5678, 4'b1111, 2'b00, AW'(199), AW'(199));
        repeat (3) idle();
        tick(1'b0, 1'b0, '0, '0, '0, 2'b10, '0, AW'(199));

        // Reset during RUN, then again at INIT count 100
        tick(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
        tick(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
        repeat (100) rnd_tick(1'b0);
        tick(1'b1, 1'b1, AW'(5), 32'd1, 4'b1111, 2'b11, AW'(5), AW'(5));
        run_init();
        tick(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(5), AW'(7));
        idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                tick(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
                run_init();
            end else begin
                rnd_tick(1'b0);
            end
        end
        idle();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
